rs_switch_bank: RTL and testbench
=================================

RS_SWITCH_BANK -- requirements
Module: rs_switch_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent switch channels (1..32).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, post-transition lockout in clk cycles (0 disables lockout).
REQ-003 SHALL have parameter SR_PRIO, default 0, simultaneous S/R resolution: 0 = reset wins, 1 = set wins, 2 = no change.
REQ-004 SHALL have parameter EDGE_MODE, default 1; 1 = S/R act on rising edge, 0 = S/R act on level every cycle.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s  input  N_CH  per-channel set request, synchronous to clk.
REQ-008 r  input  N_CH  per-channel reset request, synchronous to clk.
REQ-009 clr_all  input  1  global clear of all channels.
REQ-010 q  output  N_CH  registered switch state.
REQ-011 q_b  output  N_CH  always exact complement of q.
REQ-012 busy  output  N_CH  channel in lockout (HOLD state).
REQ-013 err_sim  output  N_CH  one-cycle pulse on a simultaneous S and R request.

Function
REQ-014 Request detection: EDGE_MODE=1 -> s_req = s & ~s_d; EDGE_MODE=0 -> s_req = s; r_req likewise.
- s_d and r_d are registered copies of s and r.
REQ-015 s_req & r_req in the same cycle SHALL resolve per SR_PRIO and pulse err_sim[i] the next cycle.
REQ-016 Resolved command SHALL be NONE, SET or RST.
- A SET with q=1 or an RST with q=0 is a no-op: no state change and no lockout.
REQ-017 Per-channel FSM states: IDLE and HOLD.
REQ-018 IDLE with a state-changing command: q updates at the next edge (1-cycle latency from sampled input).
- If HOLD_CYCLES>0, the channel enters HOLD with cnt = HOLD_CYCLES-1 and busy=1 in the same cycle as the new q.
REQ-019 HOLD: cnt decrements each cycle and q is frozen.
- Any command received in HOLD is stored in a one-deep pending register; a later command overwrites it (last wins).
REQ-020 HOLD with cnt==0: at the next edge, a pending command is applied if it changes q and reloads HOLD; otherwise the channel returns to IDLE with busy=0.
- The pending register is cleared in both cases.
REQ-021 Lockout SHALL hold q constant for exactly HOLD_CYCLES cycles after each transition.
REQ-022 HOLD_CYCLES=0: the FSM stays in IDLE, busy stays 0, and every state-changing command applies with 1-cycle latency.
REQ-023 clr_all=1 at an edge SHALL force q=0, state IDLE, busy=0 and pending cleared on all channels, overriding s, r and lockout.
- Emergency clear; err_sim is suppressed that cycle.
REQ-024 Counter width SHALL be $clog2(HOLD_CYCLES+1), minimum 1, with no wrap beyond 0.
REQ-025 Channels SHALL be fully independent apart from clr_all and reset.

Reset
REQ-026 reset SHALL take precedence over clr_all, s and r.
REQ-027 On reset: q=0, q_b=all ones, busy=0, err_sim=0, all FSMs IDLE, cnt=0, pending cleared, s_d=r_d=0.
REQ-028 Because s_d resets to 0, an s held high through reset release SHALL count as a rising edge in EDGE_MODE=1.

Structure
REQ-029 Package rs_bank_pkg SHALL hold the command enum (CMD_NONE, CMD_SET, CMD_RST), the state enum (ST_IDLE, ST_HOLD) and the SR_PRIO constants (PRIO_RST, PRIO_SET, PRIO_HOLD).
REQ-030 Sub-module rs_chan SHALL implement one channel (edge detect, resolve, FSM, counter, pending).
- rs_switch_bank instantiates N_CH copies in a generate loop and ANDs/ORs nothing beyond fan-out of clk, reset and clr_all.

Verification (N_CH=4, HOLD_CYCLES=8, SR_PRIO=0, EDGE_MODE=1 unless stated)
REQ-031 Basic set: s[0] rises at cycle 10.
- q[0]=1 and q_b[0]=0 at cycle 11.
- busy[0]=1 for cycles 11..18, then 0 at cycle 19.
REQ-032 Lockout and pending: s[1] edge at cycle 10, then r[1] edge at cycle 13 and again at cycle 15.
- q[1]=1 for cycles 11..18, q[1]=0 at cycle 19, busy[1]=1 for cycles 19..26.
REQ-033 Simultaneous request: s[2] and r[2] edges together with q[2]=0.
- q[2] stays 0 and err_sim[2] pulses 1 cycle.
- With SR_PRIO=1, q[2]=1 next cycle; with SR_PRIO=2, q[2] stays 0.
REQ-034 No-op and level mode: SET on q=1 -> busy stays 0.
- With EDGE_MODE=0 and HOLD_CYCLES=0, s[3] held high 5 cycles -> q[3]=1 after 1 cycle and no toggling.
REQ-035 Clear and reset mid-operation: clr_all pulsed during HOLD with a pending SET -> all q=0 and busy=0 next cycle, and the pending SET is never applied.
- reset asserted mid-HOLD -> REQ-027 values next cycle.
- s held high across reset release -> q=1 one cycle after release.

Source files
------------

// File: rtl/rs_bank_pkg.sv
// Shared types and helpers for the set/reset switch bank: command and
// state encodings, simultaneous-request priority codes and small decoders.
package rs_bank_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_SET  = 2'd1,
    CMD_RST  = 2'd2
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int PRIO_RST  = 32'sd0;
  localparam int PRIO_SET  = 32'sd1;
  localparam int PRIO_HOLD = 32'sd2;

  // Turn the detected set/reset requests into one command.
  function automatic cmd_e resolve_cmd(input logic s_req, input logic r_req, input int prio);
    cmd_e cmd;
    cmd = CMD_NONE;
    if (s_req && r_req) begin
      case (prio)
        PRIO_SET:  cmd = CMD_SET;
        PRIO_HOLD: cmd = CMD_NONE;
        default:   cmd = CMD_RST;
      endcase
    end else if (s_req) begin
      cmd = CMD_SET;
    end else if (r_req) begin
      cmd = CMD_RST;
    end else begin
      cmd = CMD_NONE;
    end
    return cmd;
  endfunction

  // True when the command would actually flip the switch.
  function automatic logic changes_q(input cmd_e cmd, input logic q);
    return ((cmd == CMD_SET) && !q) || ((cmd == CMD_RST) && q);
  endfunction

  // Lockout counter width; never below one bit so HOLD_CYCLES=0 still elaborates.
  function automatic int cnt_width(input int hold);
    return (hold > 32'sd0) ? $clog2(hold + 32'sd1) : 32'sd1;
  endfunction

endpackage

// File: rtl/rs_chan.sv
// One switch channel: request edge detection, S/R resolution, lockout FSM
// with down-counter, and a one-deep pending command captured during lockout.
module rs_chan
  import rs_bank_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int SR_PRIO     = 0,
  parameter int EDGE_MODE   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  input  logic clr_all,
  output logic q,
  output logic q_b,
  output logic busy,
  output logic err_sim
);

  localparam int             CNT_W    = cnt_width(HOLD_CYCLES);
  localparam bit             HOLD_EN  = (HOLD_CYCLES > 32'sd0);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
  // Loading HOLD_CYCLES-1 makes the lockout span exactly HOLD_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = HOLD_EN ? CNT_W'(HOLD_CYCLES - 32'sd1) : CNT_ZERO;

  logic             s_d_r;
  logic             r_d_r;
  logic             q_r;
  logic             q_b_r;
  logic             busy_r;
  logic             err_sim_r;
  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  cmd_e             pend_r;

  logic             s_req_s;
  logic             r_req_s;
  cmd_e             cmd_s;
  cmd_e             eff_cmd_s;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  cmd_e             pend_nxt_s;
  logic             q_nxt_s;

  // Request detection: rising edge against the registered copy, or raw level.
  always_comb begin
    if (EDGE_MODE != 32'sd0) begin
      s_req_s = s & ~s_d_r;
      r_req_s = r & ~r_d_r;
    end else begin
      s_req_s = s;
      r_req_s = r;
    end
  end

  assign cmd_s = resolve_cmd(s_req_s, r_req_s, SR_PRIO);

  // Next-state logic for the IDLE/HOLD lockout FSM, counter, pending slot and q.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pend_nxt_s  = pend_r;
    q_nxt_s     = q_r;
    eff_cmd_s   = CMD_NONE;
    case (state_r)
      ST_IDLE: begin
        if (changes_q(cmd_s, q_r)) begin
          q_nxt_s = (cmd_s == CMD_SET);
          if (HOLD_EN) begin
            state_nxt_s = ST_HOLD;
            cnt_nxt_s   = CNT_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (cmd_s != CMD_NONE) begin
            pend_nxt_s = cmd_s;
          end else begin
            pend_nxt_s = pend_r;
          end
        end else begin
          // Last cycle of lockout: a command arriving now is the newest one.
          if (cmd_s != CMD_NONE) begin
            eff_cmd_s = cmd_s;
          end else begin
            eff_cmd_s = pend_r;
          end
          pend_nxt_s = CMD_NONE;
          if (changes_q(eff_cmd_s, q_r)) begin
            q_nxt_s     = (eff_cmd_s == CMD_SET);
            state_nxt_s = ST_HOLD;
            cnt_nxt_s   = CNT_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
        pend_nxt_s  = CMD_NONE;
      end
    endcase
  end

  // State and output registers; reset beats clear, clear beats requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_d_r     <= 1'b0;
      r_d_r     <= 1'b0;
      q_r       <= 1'b0;
      q_b_r     <= 1'b1;
      busy_r    <= 1'b0;
      err_sim_r <= 1'b0;
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      pend_r    <= CMD_NONE;
    end else if (clr_all) begin
      s_d_r     <= s;
      r_d_r     <= r;
      q_r       <= 1'b0;
      q_b_r     <= 1'b1;
      busy_r    <= 1'b0;
      err_sim_r <= 1'b0;
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      pend_r    <= CMD_NONE;
    end else begin
      s_d_r     <= s;
      r_d_r     <= r;
      q_r       <= q_nxt_s;
      q_b_r     <= ~q_nxt_s;
      busy_r    <= (state_nxt_s == ST_HOLD);
      err_sim_r <= s_req_s & r_req_s;
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pend_r    <= pend_nxt_s;
    end
  end

  assign q       = q_r;
  assign q_b     = q_b_r;
  assign busy    = busy_r;
  assign err_sim = err_sim_r;

endmodule

// File: rtl/rs_switch_bank.sv
// Bank of N_CH independent set/reset switches with lockout; the channels
// share only clk, reset and the emergency clear.
module rs_switch_bank #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int SR_PRIO     = 0,
  parameter int EDGE_MODE   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] s,
  input  logic [N_CH-1:0] r,
  input  logic            clr_all,
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] q_b,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] err_sim
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    rs_chan #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .SR_PRIO     (SR_PRIO),
      .EDGE_MODE   (EDGE_MODE)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .s       (s[i]),
      .r       (r[i]),
      .clr_all (clr_all),
      .q       (q[i]),
      .q_b     (q_b[i]),
      .busy    (busy[i]),
      .err_sim (err_sim[i])
    );
  end

endmodule

// File: tb/tb_rs_switch_bank.sv
// Scoreboard bench: stimulus pushes cycle-tagged expectations, a negedge
// monitor pops and compares them. Three banks: A default, B level mode with
// no lockout and set-wins, C default except simultaneous requests do nothing.
module tb_rs_switch_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_all = 1'b0;
  logic [3:0] s = 4'b0000, r = 4'b0000;
  logic [3:0] sb = 4'b0000, rb = 4'b0000;
  logic [3:0] qa, qba, ba, ea;
  logic [3:0] qb, qbb, bb, eb;
  logic [3:0] qc, qbc, bc, ec;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] q;
    logic [3:0] busy;
    logic [3:0] err;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  logic [3:0] mq, mqb, mb, me;

  rs_switch_bank #(.N_CH(4), .HOLD_CYCLES(8), .SR_PRIO(0), .EDGE_MODE(1)) dut_a (
    .clk(clk), .reset(reset), .s(s), .r(r), .clr_all(clr_all),
    .q(qa), .q_b(qba), .busy(ba), .err_sim(ea));

  rs_switch_bank #(.N_CH(4), .HOLD_CYCLES(0), .SR_PRIO(1), .EDGE_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .s(sb), .r(rb), .clr_all(clr_all),
    .q(qb), .q_b(qbb), .busy(bb), .err_sim(eb));

  rs_switch_bank #(.N_CH(4), .HOLD_CYCLES(8), .SR_PRIO(2), .EDGE_MODE(1)) dut_c (
    .clk(clk), .reset(reset), .s(s), .r(r), .clr_all(clr_all),
    .q(qc), .q_b(qbc), .busy(bc), .err_sim(ec));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Insert an expectation keeping the queue ordered by cycle.
  task automatic push_exp(input int k, input int sel, input logic [3:0] q,
                          input logic [3:0] b, input logic [3:0] e, input string tag);
    exp_t x;
    int idx;
    x.cyc = k; x.sel = sel; x.q = q; x.busy = b; x.err = e; x.tag = tag;
    idx = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > k) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, x);
  endtask

  // Banks A and C behave identically unless simultaneous requests occur.
  task automatic push_ac(input int k, input logic [3:0] q, input logic [3:0] b,
                         input logic [3:0] e, input string tag);
    push_exp(k, 0, q, b, e, tag);
    push_exp(k, 2, q, b, e, tag);
  endtask

  task automatic at(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e_mon = exp_q.pop_front();
      case (e_mon.sel)
        1:       begin mq = qb; mqb = qbb; mb = bb; me = eb; end
        2:       begin mq = qc; mqb = qbc; mb = bc; me = ec; end
        default: begin mq = qa; mqb = qba; mb = ba; me = ea; end
      endcase
      total = total + 1;
      if (e_mon.cyc != cyc || mq !== e_mon.q || mqb !== ~e_mon.q ||
          mb !== e_mon.busy || me !== e_mon.err) begin
        bad = bad + 1;
        $display("FAIL %s dut=%0d cyc=%0d(due %0d): got q=%b q_b=%b busy=%b err=%b, want q=%b q_b=%b busy=%b err=%b",
                 e_mon.tag, e_mon.sel, cyc, e_mon.cyc, mq, mqb, mb, me,
                 e_mon.q, ~e_mon.q, e_mon.busy, e_mon.err);
      end
    end
  end

  initial begin
    // Reset state for all banks.
    for (int d = 0; d < 3; d++) push_exp(3, d, 4'b0000, 4'b0000, 4'b0000, "reset_state");
    at(3);
    reset = 1'b0;

    // A/C: basic set on ch0, lockout with pending RST on ch1.
    push_ac(10, 4'b0000, 4'b0000, 4'b0000, "pre_set");
    push_ac(11, 4'b0011, 4'b0011, 4'b0000, "set_latency");
    push_ac(13, 4'b0011, 4'b0011, 4'b0000, "hold_frozen13");
    push_ac(15, 4'b0011, 4'b0011, 4'b0000, "hold_frozen15");
    push_ac(18, 4'b0011, 4'b0011, 4'b0000, "hold_last");
    push_ac(19, 4'b0001, 4'b0010, 4'b0000, "pending_rst_applied");
    push_ac(26, 4'b0001, 4'b0010, 4'b0000, "second_hold_last");
    push_ac(27, 4'b0001, 4'b0000, 4'b0000, "back_idle");
    // B: level mode, no lockout, set wins.
    push_exp(11, 1, 4'b1000, 4'b0000, 4'b0000, "lvl_set");
    push_exp(12, 1, 4'b1000, 4'b0000, 4'b0000, "lvl_no_toggle12");
    push_exp(14, 1, 4'b1000, 4'b0000, 4'b0000, "lvl_no_toggle14");
    push_exp(15, 1, 4'b1000, 4'b0000, 4'b0000, "lvl_no_toggle15");
    push_exp(16, 1, 4'b1000, 4'b0000, 4'b0000, "lvl_hold_after_s_low");
    push_exp(17, 1, 4'b0000, 4'b0000, 4'b0000, "lvl_rst");
    push_exp(21, 1, 4'b0100, 4'b0000, 4'b0100, "lvl_sim_set_wins");
    push_exp(22, 1, 4'b0100, 4'b0000, 4'b0000, "lvl_err_one_cycle");

    at(10); s = 4'b0011; sb = 4'b1000;
    at(13); r = 4'b0010;
    at(14); r = 4'b0000;
    at(15); r = 4'b0010; sb = 4'b0000;
    at(16); r = 4'b0000; rb = 4'b1000;
    at(17); rb = 4'b0000;
    at(20); sb = 4'b0100; rb = 4'b0100;
    at(21); sb = 4'b0000; rb = 4'b0000;

    // No-op SET on ch0 which is already 1.
    push_ac(31, 4'b0001, 4'b0000, 4'b0000, "noop_set");
    at(28); s = 4'b0000;
    at(30); s = 4'b0001;
    at(32); s = 4'b0000;

    // Simultaneous edges on ch0 (q=1) and ch2 (q=0).
    push_exp(34, 0, 4'b0000, 4'b0001, 4'b0101, "sim_rst_wins");
    push_exp(35, 0, 4'b0000, 4'b0001, 4'b0000, "sim_err_pulse_end");
    push_exp(38, 0, 4'b0000, 4'b0001, 4'b0000, "hold_with_pending_set");
    push_exp(34, 2, 4'b0001, 4'b0000, 4'b0101, "sim_no_change");
    push_exp(35, 2, 4'b0001, 4'b0000, 4'b0000, "sim_err_pulse_end");
    push_exp(38, 2, 4'b0001, 4'b0000, 4'b0000, "set_noop_after_sim");
    at(33); s = 4'b0101; r = 4'b0101;
    at(36); s = 4'b0000; r = 4'b0000;

    // Clear during lockout with pending SET on A ch0; simultaneous edge masked.
    for (int d = 0; d < 3; d++) push_exp(40, d, 4'b0000, 4'b0000, 4'b0000, "clr_all");
    push_exp(42, 0, 4'b0000, 4'b0000, 4'b0000, "pending_dropped42");
    push_exp(43, 0, 4'b0000, 4'b0000, 4'b0000, "pending_dropped43");
    at(37); s = 4'b0001;
    at(39); s = 4'b0101; r = 4'b0100; clr_all = 1'b1;
    at(40); s = 4'b0000; r = 4'b0000; clr_all = 1'b0;

    // Reset mid-lockout, then s held high across reset release.
    push_ac(46, 4'b0010, 4'b0010, 4'b0000, "set_before_reset");
    push_ac(48, 4'b0010, 4'b0010, 4'b0000, "hold_before_reset");
    for (int d = 0; d < 3; d++) push_exp(49, d, 4'b0000, 4'b0000, 4'b0000, "reset_mid_hold");
    for (int d = 0; d < 3; d++) push_exp(50, d, 4'b0000, 4'b0000, 4'b0000, "reset_held");
    push_ac(51, 4'b0011, 4'b0011, 4'b0000, "s_across_release");
    push_exp(51, 1, 4'b0000, 4'b0000, 4'b0000, "lvl_idle_after_reset");
    at(45); s = 4'b0010;
    at(48); reset = 1'b1; s = 4'b0011;
    at(50); reset = 1'b0;
    at(55);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad = bad + 1;
      $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
